sram_bus_arbiter: RTL and testbench

// - Shares one req/addr_ok/data_ok memory port between IF (inst) and EX/MEM (data) requesters.
// - Chooses a requester, holds the address phase until the port accepts it, and routes each in-order

---
 rtl/sram_bus_arbiter_if.sv | 24 ++
 rtl/sram_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like request/response bus: one address phase (req/addr_ok) and
// one in-order response phase (data_ok/rdata).
// The master drives the request fields; the slave answers with addr_ok/data_ok/rdata.
interface sram_bus_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like memory port between the instruction
// fetch requester (inst) and the load/store requester (data).
// - The address phase is held on the chosen requester until the port accepts it.
// - Each in-order response is steered back to its owner through a MAX_OUT-deep
//   owner FIFO (1 = data, 0 = inst).
// - Optional macro SRAM_ARB_RR_EN: round-robin arbitration when both sides
//   request in IDLE. Without it, data has fixed priority.
module sram_bus_arbiter #(
    parameter int MAX_OUT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    sram_bus_arbiter_if.slave       inst,
    sram_bus_arbiter_if.slave       data,
    sram_bus_arbiter_if.master      mem
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD_I = 2'd1,
        ST_HOLD_D = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic               r_owner [MAX_OUT];
    // Set by reset and cleared one cycle after it: keeps every output low
    // during reset and the first cycle that follows.
    logic               r_block;

    logic               w_active;
    logic               w_not_full;
    logic               w_idle_sel_data;
    logic               w_sel_data;
    logic               w_mem_req;
    logic               w_accept;
    logic               w_pop;
    logic               w_pop_data;

    // Pointer step with explicit wrap so non-matching widths never occur.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUT - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_active   = ~reset & ~r_block;
    assign w_not_full = (r_count < CNT_W'(MAX_OUT));

`ifdef SRAM_ARB_RR_EN
    logic r_rr_last;  // owner of the most recent accept (1 = data)

    // Round-robin pick in IDLE: on a conflict, grant the side not served last.
    always_comb begin
        w_idle_sel_data = data.req;
        if (inst.req & data.req) begin
            w_idle_sel_data = ~r_rr_last;
        end
    end

    // Remember who won the most recent address phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_last <= 1'b0;
        end else if (w_accept) begin
            r_rr_last <= w_sel_data;
        end
    end
`else
    // Fixed priority in IDLE: data wins whenever it requests.
    always_comb begin
        w_idle_sel_data = data.req;
    end
`endif

    // Requester selection and port request; a hold pins the owner until addr_ok.
    always_comb begin
        w_sel_data = w_idle_sel_data;
        w_mem_req  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Uses the registered count only, so a same-cycle pop never
                // opens a full port (no data_ok -> req combinational path).
                w_mem_req = w_active & (inst.req | data.req) & w_not_full;
            end
            ST_HOLD_I: begin
                w_sel_data = 1'b0;
                w_mem_req  = w_active;
            end
            ST_HOLD_D: begin
                w_sel_data = 1'b1;
                w_mem_req  = w_active;
            end
            default: begin
                w_mem_req = 1'b0;
            end
        endcase
    end

    assign w_accept   = w_mem_req & mem.addr_ok;
    assign w_pop      = w_active & mem.data_ok & (r_count != '0);
    assign w_pop_data = r_owner[r_rd_ptr];

    // Shared port request fields: mux of the selected side, zero when idle.
    always_comb begin
        mem.req   = w_mem_req;
        mem.wr    = 1'b0;
        mem.size  = 2'd0;
        mem.addr  = 32'd0;
        mem.wstrb = 4'd0;
        mem.wdata = 32'd0;
        if (w_mem_req) begin
            if (w_sel_data) begin
                mem.wr    = data.wr;
                mem.size  = data.size;
                mem.addr  = data.addr;
                mem.wstrb = data.wstrb;
                mem.wdata = data.wdata;
            end else begin
                mem.wr    = inst.wr;
                mem.size  = inst.size;
                mem.addr  = inst.addr;
                mem.wstrb = inst.wstrb;
                mem.wdata = inst.wdata;
            end
        end
    end

    // Handshakes and response steering back to each requester.
    always_comb begin
        inst.addr_ok = w_accept & ~w_sel_data;
        data.addr_ok = w_accept &  w_sel_data;
        inst.data_ok = w_pop & ~w_pop_data;
        data.data_ok = w_pop &  w_pop_data;
        inst.rdata   = (w_pop & ~w_pop_data) ? mem.rdata : 32'd0;
        data.rdata   = (w_pop &  w_pop_data) ? mem.rdata : 32'd0;
    end

    // Control state: FSM, outstanding count and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_block  <= 1'b1;
        end else begin
            r_block <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_mem_req & ~mem.addr_ok) begin
                        r_state <= w_sel_data ? ST_HOLD_D : ST_HOLD_I;
                    end
                end
                ST_HOLD_I, ST_HOLD_D: begin
                    if (mem.addr_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_accept) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_accept & ~w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop & ~w_accept) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Owner FIFO storage; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_owner[r_wr_ptr] <= w_sel_data;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter (MAX_OUT = 2). Inputs change 1 time
// unit after each rising edge; combinational outputs are checked 1 unit later.
module tb_sram_bus_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   rr = 1'b0;

    sram_bus_arbiter_if inst_bus ();
    sram_bus_arbiter_if data_bus ();
    sram_bus_arbiter_if mem_bus ();

    sram_bus_arbiter #(.MAX_OUT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_bus),
        .data  (data_bus),
        .mem   (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef SRAM_ARB_RR_EN
        rr = 1'b1;
`endif
        reset = 1'b1;
        inst_bus.req = 1'b1; inst_bus.wr = 1'b0; inst_bus.size = 2'd2;
        inst_bus.addr = 32'h1c000000; inst_bus.wstrb = 4'h0; inst_bus.wdata = 32'h0;
        data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd2;
        data_bus.addr = 32'h0; data_bus.wstrb = 4'h0; data_bus.wdata = 32'h0;
        mem_bus.addr_ok = 1'b1; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0;

        // Reset held: everything low even with requests and handshakes active
        #1;
        chk("rst_mem_req", 32'(mem_bus.req), 32'd0);
        chk("rst_inst_addr_ok", 32'(inst_bus.addr_ok), 32'd0);
        chk("rst_inst_data_ok", 32'(inst_bus.data_ok), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_mem_req", 32'(mem_bus.req), 32'd0);
        chk("post_rst_inst_addr_ok", 32'(inst_bus.addr_ok), 32'd0);
        tick();

        // Single inst read
        mem_bus.data_ok = 1'b0;
        #1;
        chk("t1_mem_req", 32'(mem_bus.req), 32'd1);
        chk("t1_mem_addr", mem_bus.addr, 32'h1c000000);
        chk("t1_mem_size", 32'(mem_bus.size), 32'd2);
        chk("t1_inst_addr_ok", 32'(inst_bus.addr_ok), 32'd1);
        chk("t1_data_addr_ok", 32'(data_bus.addr_ok), 32'd0);
        tick();
        inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h02800c0c;
        #1;
        chk("t1_mem_req_off", 32'(mem_bus.req), 32'd0);
        chk("t1_inst_addr_ok_once", 32'(inst_bus.addr_ok), 32'd0);
        chk("t1_inst_data_ok", 32'(inst_bus.data_ok), 32'd1);
        chk("t1_inst_rdata", inst_bus.rdata, 32'h02800c0c);
        chk("t1_data_data_ok", 32'(data_bus.data_ok), 32'd0);
        tick();

        // Response with empty FIFO is ignored
        mem_bus.rdata = 32'hdeadbeef;
        #1;
        chk("empty_inst_data_ok", 32'(inst_bus.data_ok), 32'd0);
        chk("empty_data_data_ok", 32'(data_bus.data_ok), 32'd0);
        chk("empty_inst_rdata", inst_bus.rdata, 32'h0);
        tick();
        mem_bus.data_ok = 1'b0;

        // Conflict: data first; second conflict depends on arbitration mode
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000004;
        data_bus.req = 1'b1; data_bus.addr = 32'h80000010;
        mem_bus.addr_ok = 1'b1;
        #1;
        chk("c1_mem_addr", mem_bus.addr, 32'h80000010);
        chk("c1_data_addr_ok", 32'(data_bus.addr_ok), 32'd1);
        chk("c1_inst_addr_ok", 32'(inst_bus.addr_ok), 32'd0);
        tick();
        data_bus.addr = 32'h80000014;
        #1;
        chk("c2_mem_addr", mem_bus.addr, rr ? 32'h1c000004 : 32'h80000014);
        chk("c2_inst_addr_ok", 32'(inst_bus.addr_ok), rr ? 32'd1 : 32'd0);
        chk("c2_data_addr_ok", 32'(data_bus.addr_ok), rr ? 32'd0 : 32'd1);
        tick();
        inst_bus.req = 1'b0; data_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h11111111;
        #1;
        chk("c_pop1_data_ok", 32'(data_bus.data_ok), 32'd1);
        chk("c_pop1_data_rdata", data_bus.rdata, 32'h11111111);
        chk("c_pop1_inst_data_ok", 32'(inst_bus.data_ok), 32'd0);
        tick();
        mem_bus.rdata = 32'h22222222;
        #1;
        chk("c_pop2_inst_data_ok", 32'(inst_bus.data_ok), rr ? 32'd1 : 32'd0);
        chk("c_pop2_data_data_ok", 32'(data_bus.data_ok), rr ? 32'd0 : 32'd1);
        tick();
        // The side that lost both conflicts is served alone
        mem_bus.data_ok = 1'b0; mem_bus.addr_ok = 1'b1;
        inst_bus.req = ~rr; data_bus.req = rr;
        #1;
        chk("c3_mem_addr", mem_bus.addr, rr ? 32'h80000014 : 32'h1c000004);
        chk("c3_inst_addr_ok", 32'(inst_bus.addr_ok), rr ? 32'd0 : 32'd1);
        tick();
        inst_bus.req = 1'b0; data_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h33333333;
        #1;
        chk("c3_pop_inst_data_ok", 32'(inst_bus.data_ok), rr ? 32'd0 : 32'd1);
        chk("c3_pop_data_data_ok", 32'(data_bus.data_ok), rr ? 32'd1 : 32'd0);
        tick();
        mem_bus.data_ok = 1'b0;

        // Hold: inst waits 3 cycles, data arrives during the hold
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000040;
        #1;
        chk("h1_mem_req", 32'(mem_bus.req), 32'd1);
        chk("h1_mem_addr", mem_bus.addr, 32'h1c000040);
        chk("h1_inst_addr_ok", 32'(inst_bus.addr_ok), 32'd0);
        tick();
        data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.addr = 32'h80000020;
        #1;
        chk("h2_mem_addr", mem_bus.addr, 32'h1c000040);
        chk("h2_mem_wr", 32'(mem_bus.wr), 32'd0);
        chk("h2_mem_req", 32'(mem_bus.req), 32'd1);
        tick();
        #1;
        chk("h3_mem_addr", mem_bus.addr, 32'h1c000040);
        chk("h3_data_addr_ok", 32'(data_bus.addr_ok), 32'd0);
        tick();
        mem_bus.addr_ok = 1'b1;
        #1;
        chk("h4_inst_addr_ok", 32'(inst_bus.addr_ok), 32'd1);
        chk("h4_data_addr_ok", 32'(data_bus.addr_ok), 32'd0);
        chk("h4_mem_addr", mem_bus.addr, 32'h1c000040);
        tick();
        inst_bus.req = 1'b0;
        #1;
        chk("h5_data_addr_ok", 32'(data_bus.addr_ok), 32'd1);
        chk("h5_mem_addr", mem_bus.addr, 32'h80000020);
        tick();
        data_bus.req = 1'b0; data_bus.wr = 1'b0; mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h44444444;
        #1;
        chk("h_pop1_inst_data_ok", 32'(inst_bus.data_ok), 32'd1);
        tick();
        #1;
        chk("h_pop2_data_data_ok", 32'(data_bus.data_ok), 32'd1);
        chk("h_pop2_inst_data_ok", 32'(inst_bus.data_ok), 32'd0);
        tick();
        mem_bus.data_ok = 1'b0;

        // Full: data write then inst read, third request blocked
        data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.addr = 32'h80000100;
        data_bus.wstrb = 4'hf; data_bus.wdata = 32'hcafef00d;
        mem_bus.addr_ok = 1'b1;
        #1;
        chk("f1_mem_wr", 32'(mem_bus.wr), 32'd1);
        chk("f1_mem_wdata", mem_bus.wdata, 32'hcafef00d);
        chk("f1_mem_wstrb", 32'(mem_bus.wstrb), 32'hf);
        chk("f1_data_addr_ok", 32'(data_bus.addr_ok), 32'd1);
        tick();
        data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.wstrb = 4'h0; data_bus.wdata = 32'h0;
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000080;
        #1;
        chk("f2_inst_addr_ok", 32'(inst_bus.addr_ok), 32'd1);
        chk("f2_mem_wr", 32'(mem_bus.wr), 32'd0);
        tick();
        inst_bus.addr = 32'h1c000084;
        #1;
        chk("f3_full_mem_req", 32'(mem_bus.req), 32'd0);
        chk("f3_full_inst_addr_ok", 32'(inst_bus.addr_ok), 32'd0);
        chk("f3_full_mem_addr", mem_bus.addr, 32'h0);
        tick();
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0000abcd;
        #1;
        chk("f4_full_pop_mem_req", 32'(mem_bus.req), 32'd0);
        chk("f4_data_data_ok", 32'(data_bus.data_ok), 32'd1);
        chk("f4_data_rdata", data_bus.rdata, 32'h0000abcd);
        tick();
        mem_bus.rdata = 32'h00001234;
        #1;
        chk("f5_pushpop_inst_addr_ok", 32'(inst_bus.addr_ok), 32'd1);
        chk("f5_pushpop_inst_data_ok", 32'(inst_bus.data_ok), 32'd1);
        chk("f5_pushpop_inst_rdata", inst_bus.rdata, 32'h00001234);
        tick();
        inst_bus.req = 1'b0; mem_bus.data_ok = 1'b0;
        data_bus.req = 1'b1; data_bus.addr = 32'h80000200;
        #1;
        chk("f6_data_addr_ok", 32'(data_bus.addr_ok), 32'd1);
        tick();
        data_bus.req = 1'b0;
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000088;
        #1;
        chk("f7_full_again_mem_req", 32'(mem_bus.req), 32'd0);
        tick();

        // Reset with two outstanding; late responses are ignored
        reset = 1'b1; inst_bus.req = 1'b0;
        tick();
        reset = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h55555555;
        #1;
        chk("r1_inst_data_ok", 32'(inst_bus.data_ok), 32'd0);
        chk("r1_data_data_ok", 32'(data_bus.data_ok), 32'd0);
        tick();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1c0000c0;
        #1;
        chk("r2_mem_req", 32'(mem_bus.req), 32'd1);
        chk("r2_inst_addr_ok", 32'(inst_bus.addr_ok), 32'd1);
        chk("r2_late_inst_data_ok", 32'(inst_bus.data_ok), 32'd0);
        chk("r2_late_data_data_ok", 32'(data_bus.data_ok), 32'd0);
        tick();
        inst_bus.req = 1'b0; mem_bus.rdata = 32'h66666666;
        #1;
        chk("r3_inst_data_ok", 32'(inst_bus.data_ok), 32'd1);
        chk("r3_inst_rdata", inst_bus.rdata, 32'h66666666);
        tick();
        mem_bus.data_ok = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
